// File: rtl/keypad_scan_decoder.sv
// Scans a ROWS x COLS key matrix one column at a time; debounces press and release and reports a key code.
// Latency: press/release confirmed (DEBOUNCE_TICKS-1)*SCAN_DIV+1 clocks after the first tick that sees it.
// Backpressure: none; event pulses are one clock wide and must be consumed when asserted.
module keypad_scan_decoder #(
  parameter int COLS           = 4,
  parameter int ROWS           = 4,
  parameter int KEY_W          = 4,
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_TICKS = 3
) (
  input  logic             clock_i,
  input  logic             rst_ni,
  input  logic [ROWS-1:0]  row_in_i,
  output logic [COLS-1:0]  col_drive_o,
  output logic [KEY_W-1:0] key_code_o,
  output logic             key_valid_o,
  output logic             key_down_o,
  output logic             key_release_o
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);

  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HELD} state_e;

  logic [ROWS-1:0]  sync1_q, rows_s_q;
  logic [PW-1:0]    presc_q;
  logic             tick;
  state_e           state_q, state_d;
  logic [CW-1:0]    col_idx_q, col_idx_d;
  logic [COLS-1:0]  col_drive_q, col_drive_d;
  logic [RW-1:0]    row_idx_q, row_idx_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic [KEY_W-1:0] key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_down_q, key_down_d;
  logic             key_release_q, key_release_d;

  logic [ROWS-1:0]  low_vec;
  logic             one_low;
  logic [RW-1:0]    low_row;
  logic             latched_only;
  logic             latched_high;
  logic             cnt_last;
  logic [CW-1:0]    col_adv_idx;
  logic [COLS-1:0]  col_adv_drive;
  logic [KEY_W-1:0] key_calc;

  // Two-flop synchroniser for the asynchronous row returns; idle (all high) out of reset.
  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= '1;
      rows_s_q <= '1;
    end else begin
      sync1_q  <= row_in_i;
      rows_s_q <= sync1_q;
    end
  end

  // Scan-rate prescaler: tick on the last count, then wrap.
  assign tick = (presc_q == PW'(SCAN_DIV - 1));
  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) presc_q <= '0;
    else         presc_q <= tick ? '0 : presc_q + 1'b1;
  end

  // Row sample classification and column/key arithmetic shared by all states.
  always_comb begin
    low_vec = ~rows_s_q;
    one_low = (low_vec != '0) && ((low_vec & (low_vec - ROWS'(1))) == '0);
    low_row = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (low_vec[r]) low_row = RW'(r);
    end
    latched_only  = one_low && low_vec[row_idx_q];
    latched_high  = rows_s_q[row_idx_q];
    cnt_last      = (cnt_q == DW'(DEBOUNCE_TICKS - 1));
    col_adv_idx   = (col_idx_q == CW'(COLS - 1)) ? '0 : col_idx_q + 1'b1;
    col_adv_drive = {col_drive_q[COLS-2:0], col_drive_q[COLS-1]};
    key_calc      = KEY_W'(row_idx_q) * KEY_W'(COLS) + KEY_W'(col_idx_q);
  end

  // Scan/debounce/held control: decisions only on tick clocks, pulses default low.
  always_comb begin
    state_d       = state_q;
    col_idx_d     = col_idx_q;
    col_drive_d   = col_drive_q;
    row_idx_d     = row_idx_q;
    cnt_d         = cnt_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_down_d    = key_down_q;
    key_release_d = 1'b0;
    if (tick) begin
      unique case (state_q)
        ST_SCAN: begin
          if (one_low) begin
            // Column stays put so the debounce keeps watching the same key.
            row_idx_d = low_row;
            cnt_d     = DW'(1);
            state_d   = ST_DEBOUNCE;
          end else begin
            // Nothing pressed, or a chord we cannot resolve: move on.
            col_idx_d   = col_adv_idx;
            col_drive_d = col_adv_drive;
          end
        end
        ST_DEBOUNCE: begin
          if (latched_only) begin
            if (cnt_last) begin
              key_code_d  = key_calc;
              key_valid_d = 1'b1;
              key_down_d  = 1'b1;
              cnt_d       = '0;
              state_d     = ST_HELD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d       = '0;
            col_idx_d   = col_adv_idx;
            col_drive_d = col_adv_drive;
            state_d     = ST_SCAN;
          end
        end
        ST_HELD: begin
          // Only the latched row matters; a low sample restarts the release count.
          if (latched_high) begin
            if (cnt_last) begin
              key_release_d = 1'b1;
              key_down_d    = 1'b0;
              cnt_d         = '0;
              col_idx_d     = col_adv_idx;
              col_drive_d   = col_adv_drive;
              state_d       = ST_SCAN;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  // State and output registers; column 0 is strobed out of reset.
  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_SCAN;
      col_idx_q     <= '0;
      col_drive_q   <= ~COLS'(1);
      row_idx_q     <= '0;
      cnt_q         <= '0;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      key_down_q    <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_idx_q     <= col_idx_d;
      col_drive_q   <= col_drive_d;
      row_idx_q     <= row_idx_d;
      cnt_q         <= cnt_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_down_q    <= key_down_d;
      key_release_q <= key_release_d;
    end
  end

  assign col_drive_o   = col_drive_q;
  assign key_code_o    = key_code_q;
  assign key_valid_o   = key_valid_q;
  assign key_down_o    = key_down_q;
  assign key_release_o = key_release_q;

endmodule
